// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: circular buffer feeding a dual-issue stage with two oldest words.
// Optional stall/starve statistics counters are built when IFQ_STATS_EN is defined.
module instr_fetch_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic [1:0]               consume,
  output logic [31:0]              out_instr1,
  output logic [31:0]              out_instr2,
  output logic                     out_valid1,
  output logic                     out_valid2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     consume_err
`ifdef IFQ_STATS_EN
  ,
  output logic [15:0]              full_cycles,
  output logic [15:0]              starve_cycles
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;

  logic          push;
  logic [1:0]    cons_eff;
  logic [AW:0]   cons_ext;
  logic [AW:0]   popped;
  logic [AW:0]   push_ext;
  logic [AW-1:0] rd_ptr_p1;

  assign in_ready = (count_q < FullCnt);
  assign push     = in_valid & in_ready;
  // 2'b11 is an illegal request; serve it as 2 and flag it.
  assign cons_eff = (consume == 2'b11) ? 2'b10 : consume;
  assign cons_ext = {{(AW-1){1'b0}}, cons_eff};
  assign popped   = (cons_ext > count_q) ? count_q : cons_ext;
  assign push_ext = {{AW{1'b0}}, push};

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + popped[AW-1:0];
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      count_d = count_q + push_ext - popped;
      if ((consume == 2'b11) || (cons_ext > count_q)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage is deliberately not reset; the valid flags gate what is exposed.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_q] <= in_instr;
    end
  end

  assign rd_ptr_p1   = rd_ptr_q + 1'b1;
  assign out_valid1  = (count_q >= (AW+1)'(1));
  assign out_valid2  = (count_q >= (AW+1)'(2));
  assign out_instr1  = out_valid1 ? mem[rd_ptr_q] : Nop;
  assign out_instr2  = out_valid2 ? mem[rd_ptr_p1] : Nop;
  assign count       = count_q;
  assign consume_err = err_q;

`ifdef IFQ_STATS_EN
  logic [15:0] full_q, starve_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= '0;
      starve_q <= '0;
    end else begin
      if ((count_q == FullCnt) && (full_q != 16'hFFFF)) begin
        full_q <= full_q + 16'd1;
      end
      if ((count_q < (AW+1)'(2)) && (starve_q != 16'hFFFF)) begin
        starve_q <= starve_q + 16'd1;
      end
    end
  end

  assign full_cycles   = full_q;
  assign starve_cycles = starve_q;
`endif

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue capacity in 32-bit instruction words; SHALL be a power of two, minimum 4.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid  input  1  I-cache word valid this cycle.
REQ-005 in_instr  input  32  instruction word from I-cache.
REQ-006 in_ready  output  1  queue accepts a word this cycle.
REQ-007 flush  input  1  discard all queued words.
REQ-008 consume  input  2  words taken by the issue stage this cycle (0, 1 or 2).
REQ-009 out_instr1  output  32  oldest queued word (issue-unit instr1).
REQ-010 out_instr2  output  32  second-oldest queued word (issue-unit instr2).
REQ-011 out_valid1 / out_valid2  output  1 each  the corresponding slot holds a real word.
REQ-012 count  output  log2(DEPTH)+1  number of occupied entries.
REQ-013 consume_err  output  1  sticky flag: consume exceeded the valid words.

Function
REQ-014 Storage: circular buffer of DEPTH words, read pointer rd_ptr, write pointer wr_ptr, count register; pointers wrap modulo DEPTH.
REQ-015 in_ready SHALL be 1 iff count < DEPTH, based on the current count; a same-cycle pop does not raise in_ready.
REQ-016 Push: when in_valid & in_ready, write in_instr at wr_ptr and increment wr_ptr.
REQ-017 Pop: popped = min(consume, count); advance rd_ptr by popped.
REQ-018 count_next = count + push - popped; simultaneous push and pop are both applied in the same cycle.
REQ-019 out_instr1 = mem[rd_ptr] and out_instr2 = mem[rd_ptr+1 mod DEPTH]; these are combinational from current state.
REQ-020 out_valid1 = (count >= 1) and out_valid2 = (count >= 2); an invalid slot outputs the NOP 32'h00000013.
REQ-021 Latency: a word pushed at edge N appears on an output at the earliest after edge N, with no same-cycle bypass.
REQ-022 Order: words leave in push order; consume=1 moves out_instr2 to out_instr1 on the next cycle. This supports issue-unit hold-and-rollback.
REQ-023 If consume > count, pop only count words and set consume_err to 1; the flag stays set until reset.
REQ-024 consume = 2'b11 SHALL be treated as 2 and SHALL set consume_err.
REQ-025 flush has priority over push and pop: the next state is rd_ptr = wr_ptr = 0 and count = 0. A simultaneous push is dropped. consume_err is unchanged.
REQ-026 At the wrap boundary, when rd_ptr = DEPTH-1, out_instr2 SHALL read entry 0.

Reset
REQ-027 On rst: rd_ptr = wr_ptr = 0, count = 0, consume_err = 0, and any enabled statistics counters = 0. As a result, in_ready = 1, out_valid1 = out_valid2 = 0, and out_instr1 = out_instr2 = 32'h00000013 immediately, without waiting for a clock edge.
REQ-028 Storage contents are not reset. Outputs never expose storage contents while the corresponding valid flag is 0.
REQ-029 Reset asserted mid-operation discards all entries; the first push after reset deassertion lands in entry 0.

Configuration
REQ-030 Macro IFQ_STATS_EN defined:
- adds output full_cycles (16 bits), incremented on each cycle with count == DEPTH;
- adds output starve_cycles (16 bits), incremented on each cycle with count < 2;
- both counters saturate at 16'hFFFF and are cleared by rst only.
REQ-031 Macro IFQ_STATS_EN undefined: neither port nor counter exists, and all other behaviour is identical.

Verification
REQ-032 Reset, then push A0..A3 on 4 consecutive cycles with consume=0 -> count=4; out_instr1=A0, out_instr2=A1; both valids 1.
REQ-033 From that state, apply consume=1 for one cycle -> out_instr1=A1, out_instr2=A2, count=3. Then apply consume=2 -> out_instr1=A3, out_valid2=0, out_instr2=32'h00000013, count=1.
REQ-034 DEPTH=8: push 8 words -> in_ready=0 and a 9th in_valid is ignored. Then push and consume=1 in the same cycle -> the new word is rejected and count=7.
REQ-035 Wrap: push and pop so that rd_ptr=7 and count=2 -> out_instr1=mem[7], out_instr2=mem[0]. After consume=2, count=0.
REQ-036 With count=1, apply consume=2 -> count=0 and consume_err=1, which persists. Asserting flush with in_valid=1 in the same cycle -> count=0 and the pushed word is dropped.
REQ-037 With IFQ_STATS_EN, hold the queue full for 5 cycles -> full_cycles=5. Hold it empty for 70000 cycles -> starve_cycles=16'hFFFF.
